// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between ICache refills and DCache accesses,
// alternating on ties, holding the access for MEM_LATENCY cycles, then pulsing ready.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        mem_busy
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  state_t state, nextState;
  logic [3:0] cnt;
  logic lastGrant;
  logic grantI, grantD, busy, lastCycle;
  always_comb begin
    grantD = state == IDLE && d_req && (!i_req || !lastGrant);
    grantI = state == IDLE && i_req && !grantD;
    busy = state == BUSY_I || state == BUSY_D;
    lastCycle = cnt == 4'(MEM_LATENCY - 1);
    nextState = grantD ? BUSY_D :
                grantI ? BUSY_I :
                busy && lastCycle ? DONE :
                state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  // mem_we doubles as the latched load/store flag, since d_we may change once d_req drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      lastGrant <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_data <= '0;
      d_rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      mem_busy <= 1'b0;
    end else if (grantI || grantD) begin
      mem_addr <= grantD ? d_addr : i_addr;
      mem_we <= grantD && d_we;
      if (grantD) mem_wdata <= d_wdata;
      if (i_req && d_req) lastGrant <= grantD;
      cnt <= '0;
      mem_busy <= 1'b1;
    end else if (busy) begin
      cnt <= cnt + 4'd1;
      if (lastCycle) begin
        mem_we <= 1'b0;
        if (state == BUSY_I) begin
          i_data <= mem_rdata;
          i_ready <= 1'b1;
        end else begin
          if (!mem_we) d_rdata <= mem_rdata;
          d_ready <= 1'b1;
        end
      end
    end else if (state == DONE) begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      mem_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboarded directed test of mem_arbiter at latencies 2, 1 and 15.
module tb_mem_arbiter;
  localparam int L = 2;
  logic clk = 0, rst = 1;
  logic [2:0] iReq = '0, iReady, dReq = '0, dWe = '0, dReady, memWe, memBusy;
  logic [31:0] iAddr[3], iData[3], dAddr[3], dWdata[3], dRdata[3];
  logic [31:0] memAddr[3], memWdata[3], memRdata[3];
  int cyc = 0, vectors = 0, miscompares = 0;
  typedef struct {int id; logic [31:0] data; int cyc;} exp_t;
  exp_t q[$];

  function automatic logic [31:0] memVal(input logic [31:0] a);
    return a == 32'h40 ? 32'h1234_5678 : a == 32'h80 ? 32'hA5A5_A5A5 : {16'hCAFE, a[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gDut
    assign memRdata[g] = memVal(memAddr[g]);
    mem_arbiter #(.MEM_LATENCY(g == 0 ? 2 : g == 1 ? 1 : 15)) dut (
      .clk(clk), .rst(rst),
      .i_req(iReq[g]), .i_addr(iAddr[g]), .i_data(iData[g]), .i_ready(iReady[g]),
      .d_req(dReq[g]), .d_we(dWe[g]), .d_addr(dAddr[g]), .d_wdata(dWdata[g]),
      .d_rdata(dRdata[g]), .d_ready(dReady[g]),
      .mem_addr(memAddr[g]), .mem_wdata(memWdata[g]), .mem_we(memWe[g]),
      .mem_rdata(memRdata[g]), .mem_busy(memBusy[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // monitor: ids 0/1 = main DUT I/D, 2 = latency-1 I, 3 = latency-15 I
  always @(negedge clk) begin
    for (int id = 0; id < 4; id++) begin
      logic rdy;
      logic [31:0] dat;
      rdy = id == 0 ? iReady[0] : id == 1 ? dReady[0] : id == 2 ? iReady[1] : iReady[2];
      dat = id == 0 ? iData[0] : id == 1 ? dRdata[0] : id == 2 ? iData[1] : iData[2];
      if (rdy) begin
        if (q.size() == 0) chk($sformatf("unexpected_ready_id%0d", id), 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("ready_id", id, e.id);
          chk("ready_data", dat, e.data);
          chk("ready_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic doAccess(input bit isD, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expData, input int extra);
    int c0;
    if (isD) begin
      dReq[0] = 1; dWe[0] = we; dAddr[0] = addr; dWdata[0] = wdata;
    end else begin
      iReq[0] = 1; iAddr[0] = addr;
    end
    c0 = cyc + extra;
    q.push_back('{isD ? 1 : 0, expData, c0 + L + 1});
    repeat (extra + 1) @(negedge clk);
    for (int k = 1; k <= L; k++) begin
      chk("mem_addr", memAddr[0], addr);
      chk("mem_we", {31'd0, memWe[0]}, {31'd0, isD && we});
      chk("mem_busy", {31'd0, memBusy[0]}, 32'd1);
      if (isD && we) chk("mem_wdata", memWdata[0], wdata);
      @(negedge clk);
    end
    chk("done_mem_we", {31'd0, memWe[0]}, 32'd0);
    chk("done_busy", {31'd0, memBusy[0]}, 32'd1);
    if (isD) dReq[0] = 0; else iReq[0] = 0;
  endtask

  initial begin
    int c0;
    for (int g = 0; g < 3; g++) begin
      iAddr[g] = '0; dAddr[g] = '0; dWdata[g] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_mem_addr", memAddr[0], 0);
    chk("rst_mem_wdata", memWdata[0], 0);
    chk("rst_mem_we", {31'd0, memWe[0]}, 0);
    chk("rst_mem_busy", {29'd0, memBusy}, 0);
    chk("rst_ready", {30'd0, iReady[0], dReady[0]}, 0);
    chk("rst_i_data", iData[0], 0);
    chk("rst_d_rdata", dRdata[0], 0);
    rst = 0;
    doAccess(0, 0, 32'h40, 0, 32'h1234_5678, 0);
    doAccess(1, 1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1);
    doAccess(1, 0, 32'h200, 0, 32'hCAFE_0200, 1);
    doAccess(1, 0, 32'h204, 0, 32'hCAFE_0204, 1);
    doAccess(1, 1, 32'h108, 32'h0000_55AA, 32'hCAFE_0204, 1);
    // continuous tie: grants alternate D, I, D, I every L+2 cycles
    iReq[0] = 1; iAddr[0] = 32'h300;
    dReq[0] = 1; dWe[0] = 0; dAddr[0] = 32'h400;
    c0 = cyc + 1;
    for (int k = 0; k < 4; k++)
      q.push_back('{k % 2 == 0 ? 1 : 0, k % 2 == 0 ? 32'hCAFE_0400 : 32'hCAFE_0300, c0 + 4 * k + L + 1});
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie_mem_addr%0d", k), memAddr[0], k % 2 == 0 ? 32'h400 : 32'h300);
      repeat (k < 3 ? 4 : 2) @(negedge clk);
    end
    iReq[0] = 0; dReq[0] = 0;
    @(negedge clk);
    // asynchronous reset in the first cycle of a store
    dReq[0] = 1; dWe[0] = 1; dAddr[0] = 32'h500; dWdata[0] = 32'h0000_0012;
    @(negedge clk);
    chk("pre_rst_mem_we", {31'd0, memWe[0]}, 1);
    chk("pre_rst_busy", {31'd0, memBusy[0]}, 1);
    #1 rst = 1; dReq[0] = 0;
    #1;
    chk("arst_mem_we", {31'd0, memWe[0]}, 0);
    chk("arst_busy", {31'd0, memBusy[0]}, 0);
    chk("arst_mem_addr", memAddr[0], 0);
    chk("arst_d_rdata", dRdata[0], 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, memBusy[0]}, 0);
    doAccess(0, 0, 32'h40, 0, 32'h1234_5678, 0);
    // latency extremes on the other two instances
    iReq[1] = 1; iAddr[1] = 32'h80;
    iReq[2] = 1; iAddr[2] = 32'h80;
    q.push_back('{2, 32'hA5A5_A5A5, cyc + 2});
    q.push_back('{3, 32'hA5A5_A5A5, cyc + 16});
    repeat (2) @(negedge clk);
    iReq[1] = 0;
    repeat (14) @(negedge clk);
    iReq[2] = 0;
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
